// File: rtl/bridge_pkg.sv
// Shared AHB-Lite types and constants for the bridge and its traffic sources.
// Holds bus widths, HTRANS/HBURST/HSIZE encodings and the master error-handling states.
package bridge_pkg;

  localparam int HADDR_SIZE = 32;
  localparam int HDATA_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HWORD   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // ERR_WAIT: ap cancelled, erroring transfer still in its second cycle.
  // ERR_FLUSH: one cycle to report the cancelled command.
  typedef enum logic [1:0] {
    ERR_IDLE  = 2'b00,
    ERR_WAIT  = 2'b01,
    ERR_FLUSH = 2'b10
  } err_st_t;

  function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: single commands become pipelined NONSEQ SINGLE transfers, responses in order.
// Optional macro AHB_MST_ERR_CANCEL_EN cancels the pending address phase on an ERROR response.
module ahb_lite_master
  import bridge_pkg::*;
#(
  parameter int HADDR_SIZE = bridge_pkg::HADDR_SIZE,
  parameter int HDATA_SIZE = bridge_pkg::HDATA_SIZE
) (
  input  logic                  hclk,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [HDATA_SIZE-1:0] HRDATA
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(HDATA_SIZE / 8));

  // Command handshake: cmd_valid && cmd_ready in the same cycle moves the command into
  // the address-phase register at the next hclk rise; cmd_ready never depends on cmd_valid.
  logic                  ap_valid;
  logic                  ap_write;
  logic [HADDR_SIZE-1:0] ap_addr;
  logic [2:0]            ap_size;
  logic [HDATA_SIZE-1:0] ap_wdata;
  logic                  dp_valid;
  logic                  dp_write;
  logic [HDATA_SIZE-1:0] hwdata_q;

  err_st_t err_st;
  logic    cancel;
  logic    err_state;
  logic    accept;
  logic [2:0]            size_eff;
  logic [HADDR_SIZE-1:0] addr_mask;

`ifdef AHB_MST_ERR_CANCEL_EN
  err_st_t err_nxt;

  always_ff @(posedge hclk or negedge HRESETn) begin
    if (!HRESETn) err_st <= ERR_IDLE;
    else          err_st <= err_nxt;
  end

  always_comb begin
    err_nxt = err_st;
    cancel  = 1'b0;
    case (err_st)
      ERR_IDLE: begin
        if (dp_valid && HRESP && !HREADY && ap_valid) begin
          err_nxt = ERR_WAIT;
          cancel  = 1'b1;
        end
      end
      ERR_WAIT:  if (HREADY) err_nxt = ERR_FLUSH;
      ERR_FLUSH: err_nxt = ERR_IDLE;
      default:   err_nxt = ERR_IDLE;
    endcase
  end
`else
  assign err_st = ERR_IDLE;
  assign cancel = 1'b0;
`endif

  assign err_state = (err_st != ERR_IDLE);
  assign cmd_ready = (!ap_valid || HREADY) && !err_state;
  assign accept    = cmd_valid && cmd_ready;
  assign size_eff  = clamp_size(cmd_size, MAX_SIZE);
  assign addr_mask = ~((HADDR_SIZE'(1) << size_eff) - HADDR_SIZE'(1));

  // An empty ap may be filled during a wait state (IDLE -> NONSEQ is legal there);
  // a full ap only advances when the current data phase completes.
  always_ff @(posedge hclk or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_addr  <= '0;
      ap_size  <= '0;
      ap_wdata <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      hwdata_q <= '0;
    end else begin
      if (HREADY) begin
        dp_valid <= ap_valid;
        dp_write <= ap_write;
        if (ap_valid && ap_write) hwdata_q <= ap_wdata;
        ap_valid <= accept;
      end else if (cancel) begin
        ap_valid <= 1'b0;
      end else if (accept) begin
        ap_valid <= 1'b1;
      end
      if (accept) begin
        ap_write <= cmd_write;
        ap_addr  <= cmd_addr & addr_mask;
        ap_size  <= size_eff;
        ap_wdata <= cmd_wdata;
      end
    end
  end

  always_ff @(posedge hclk or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (err_st == ERR_FLUSH) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else if (dp_valid && HREADY) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= dp_write ? '0 : HRDATA;
      rsp_err   <= HRESP;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  assign HSEL      = ap_valid;
  assign HTRANS    = ap_valid ? NONSEQ : IDLE;
  assign HADDR     = ap_addr;
  assign HWRITE    = ap_write;
  assign HSIZE     = ap_size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: cycle-exact checks plus an in-order response scoreboard.
// Expectations for the error test follow AHB_MST_ERR_CANCEL_EN when it is defined.
module tb_ahb_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = DW + 1;

  logic          hclk;
  logic          HRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic [1:0]    HTRANS;
  logic          HMASTLOCK;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HRESP;
  logic [DW-1:0] HRDATA;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  ahb_lite_master #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
    .hclk(hclk), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] addr, input logic [2:0] size,
                           input logic [DW-1:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
  endtask

  task automatic drop_cmd();
    cmd_valid = 1'b0;
  endtask

  // scoreboard: every response is compared, in order, against the expected queue
  always @(negedge hclk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else check("rsp_data", 64'({rsp_err, rsp_rdata}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_wdata = '0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;

    // 1: reset and idle
    repeat (2) @(posedge hclk);
    #3;
    check("rst_htrans", 64'(HTRANS), 64'd0);
    check("rst_hsel", 64'(HSEL), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_hburst", 64'(HBURST), 64'd0);
    check("rst_hprot", 64'(HPROT), 64'h3);
    check("rst_hmastlock", 64'(HMASTLOCK), 64'd0);
    check("rst_hwdata", 64'(HWDATA), 64'd0);
    HRESETn = 1'b1;
    step();

    // 2: single write
    drive_cmd(1'b1, 32'h4000_0010, 3'd2, 32'hDEAD_BEEF);
    #1;
    check("wr_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_q.push_back({1'b0, 32'h0});
    step();
    drop_cmd();
    check("wr_htrans", 64'(HTRANS), 64'h2);
    check("wr_hsel", 64'(HSEL), 64'd1);
    check("wr_hwrite", 64'(HWRITE), 64'd1);
    check("wr_haddr", 64'(HADDR), 64'h4000_0010);
    check("wr_hsize", 64'(HSIZE), 64'd2);
    step();
    check("wr_hwdata", 64'(HWDATA), 64'hDEAD_BEEF);
    check("wr_idle_after", 64'(HTRANS), 64'd0);
    check("wr_no_rsp_c2", 64'(rsp_valid), 64'd0);
    step();
    check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("wr_rsp_err", 64'(rsp_err), 64'd0);
    step();
    check("wr_rsp_pulse", 64'(rsp_valid), 64'd0);

    // 3: four back-to-back reads, HRDATA = addr + 0x100 during each data phase
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        drive_cmd(1'b0, 32'(i * 4), 3'd2, 32'h0);
        exp_q.push_back({1'b0, 32'(32'h100 + i * 4)});
      end else begin
        drop_cmd();
      end
      HRDATA = (i >= 2 && i <= 5) ? 32'(32'h100 + (i - 2) * 4) : 32'h0;
      #1;
      if (i >= 1 && i <= 4) begin
        check("b2b_htrans", 64'(HTRANS), 64'h2);
        check("b2b_haddr", 64'(HADDR), 64'((i - 1) * 4));
      end
      check("b2b_rsp_valid", 64'(rsp_valid), (i >= 3) ? 64'd1 : 64'd0);
      check("b2b_cmd_ready", 64'(cmd_ready), 64'd1);
      step();
    end
    check("b2b_rsp_end", 64'(rsp_valid), 64'd0);
    check("b2b_idle_end", 64'(HTRANS), 64'd0);

    // 4: read with three wait states while the next read waits in the address phase
    drive_cmd(1'b0, 32'h20, 3'd2, 32'h0);
    exp_q.push_back({1'b0, 32'h55AA});
    step();
    drive_cmd(1'b0, 32'h24, 3'd2, 32'h0);
    exp_q.push_back({1'b0, 32'h77});
    step();
    drop_cmd();
    HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1;
      check("ws_htrans", 64'(HTRANS), 64'h2);
      check("ws_haddr", 64'(HADDR), 64'h24);
      check("ws_cmd_ready", 64'(cmd_ready), 64'd0);
      check("ws_no_rsp", 64'(rsp_valid), 64'd0);
      step();
    end
    HREADY = 1'b1;
    HRDATA = 32'h55AA;
    #1;
    check("ws_haddr_last", 64'(HADDR), 64'h24);
    check("ws_cmd_ready_rel", 64'(cmd_ready), 64'd1);
    step();
    HRDATA = 32'h77;
    check("ws_rsp_a", 64'(rsp_valid), 64'd1);
    check("ws_idle", 64'(HTRANS), 64'd0);
    step();
    HRDATA = 32'h0;
    check("ws_rsp_b", 64'(rsp_valid), 64'd1);
    step();
    check("ws_rsp_done", 64'(rsp_valid), 64'd0);

    // 5: write then read, two-cycle ERROR on the write
    drive_cmd(1'b1, 32'h80, 3'd2, 32'h1234);
    exp_q.push_back({1'b1, 32'h0});
    step();
    drive_cmd(1'b0, 32'h84, 3'd2, 32'h0);
`ifdef AHB_MST_ERR_CANCEL_EN
    exp_q.push_back({1'b1, 32'h0});
`else
    exp_q.push_back({1'b0, 32'h99});
`endif
    step();
    drop_cmd();
    HREADY = 1'b0;
    HRESP  = 1'b1;
    #1;
    check("err_c1_htrans", 64'(HTRANS), 64'h2);
    check("err_c1_haddr", 64'(HADDR), 64'h84);
    check("err_c1_hwdata", 64'(HWDATA), 64'h1234);
    step();
    HREADY = 1'b1;
    #1;
`ifdef AHB_MST_ERR_CANCEL_EN
    check("err_c2_htrans", 64'(HTRANS), 64'd0);
    check("err_c2_hsel", 64'(HSEL), 64'd0);
    check("err_c2_cmd_ready", 64'(cmd_ready), 64'd0);
`else
    check("err_c2_htrans", 64'(HTRANS), 64'h2);
    check("err_c2_cmd_ready", 64'(cmd_ready), 64'd1);
`endif
    step();
    HRESP  = 1'b0;
    HRDATA = 32'h99;
    #1;
    check("err_wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("err_wr_rsp_err", 64'(rsp_err), 64'd1);
`ifdef AHB_MST_ERR_CANCEL_EN
    check("err_flush_ready", 64'(cmd_ready), 64'd0);
`else
    check("err_rd_dphase", 64'(HTRANS), 64'd0);
`endif
    step();
    HRDATA = 32'h0;
    check("err_rd_rsp_valid", 64'(rsp_valid), 64'd1);
`ifdef AHB_MST_ERR_CANCEL_EN
    check("err_rd_rsp_err", 64'(rsp_err), 64'd1);
`else
    check("err_rd_rsp_err", 64'(rsp_err), 64'd0);
`endif
    check("err_ready_after", 64'(cmd_ready), 64'd1);
    step();
    check("err_rsp_done", 64'(rsp_valid), 64'd0);

    // 6: alignment, size clamp, then reset asserted during a wait state
    drive_cmd(1'b0, 32'h13, 3'd2, 32'h0);
    step();
    drive_cmd(1'b0, 32'h1F, 3'd3, 32'h0);
    #1;
    check("align_haddr", 64'(HADDR), 64'h10);
    check("align_hsize", 64'(HSIZE), 64'd2);
    step();
    drop_cmd();
    HREADY = 1'b0;
    #1;
    check("clamp_haddr", 64'(HADDR), 64'h1C);
    check("clamp_hsize", 64'(HSIZE), 64'd2);
    check("clamp_htrans", 64'(HTRANS), 64'h2);
    #1;
    HRESETn = 1'b0;
    #1;
    check("mrst_htrans", 64'(HTRANS), 64'd0);
    check("mrst_hsel", 64'(HSEL), 64'd0);
    check("mrst_haddr", 64'(HADDR), 64'd0);
    check("mrst_hsize", 64'(HSIZE), 64'd0);
    check("mrst_hwrite", 64'(HWRITE), 64'd0);
    check("mrst_hwdata", 64'(HWDATA), 64'd0);
    check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mrst_cmd_ready", 64'(cmd_ready), 64'd1);
    #2;
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mrst_no_rsp", 64'(rsp_valid), 64'd0);
      check("mrst_idle", 64'(HTRANS), 64'd0);
    end

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
